// File: rtl/axil_cmd_arbiter.sv
// axil_cmd_arbiter: two-requester round-robin command arbiter driving a single
// AXI4-Lite master port, one transaction outstanding at a time.
// Optional feature: define AXIL_CMD_ARB_STATS_EN to add per-requester 16-bit
// saturating write/read completion counters.
// Only DATA_W = 32 is supported.
module axil_cmd_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                ACLK,
    input  logic                ARESET,

    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic                req0_we,
    input  logic [ADDR_W-1:0]   req0_addr,
    input  logic [DATA_W-1:0]   req0_wdata,
    output logic                req0_done,
    output logic [DATA_W-1:0]   req0_rdata,
    output logic [1:0]          req0_resp,

    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic                req1_we,
    input  logic [ADDR_W-1:0]   req1_addr,
    input  logic [DATA_W-1:0]   req1_wdata,
    output logic                req1_done,
    output logic [DATA_W-1:0]   req1_rdata,
    output logic [1:0]          req1_resp,

`ifdef AXIL_CMD_ARB_STATS_EN
    output logic [15:0]         req0_wr_cnt,
    output logic [15:0]         req0_rd_cnt,
    output logic [15:0]         req1_wr_cnt,
    output logic [15:0]         req1_rd_cnt,
`endif

    output logic [ADDR_W-1:0]   M_AXI_AWADDR,
    output logic [2:0]          M_AXI_AWPROT,
    output logic                M_AXI_AWVALID,
    input  logic                M_AXI_AWREADY,
    output logic [DATA_W-1:0]   M_AXI_WDATA,
    output logic [DATA_W/8-1:0] M_AXI_WSTRB,
    output logic                M_AXI_WVALID,
    input  logic                M_AXI_WREADY,
    input  logic [1:0]          M_AXI_BRESP,
    input  logic                M_AXI_BVALID,
    output logic                M_AXI_BREADY,
    output logic [ADDR_W-1:0]   M_AXI_ARADDR,
    output logic [2:0]          M_AXI_ARPROT,
    output logic                M_AXI_ARVALID,
    input  logic                M_AXI_ARREADY,
    input  logic [DATA_W-1:0]   M_AXI_RDATA,
    input  logic [1:0]          M_AXI_RRESP,
    input  logic                M_AXI_RVALID,
    output logic                M_AXI_RREADY
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StWr     = 3'd1;
    localparam logic [2:0] StWrResp = 3'd2;
    localparam logic [2:0] StRdAddr = 3'd3;
    localparam logic [2:0] StRdResp = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              owner_q, owner_d;   // 0 = req0 owns the in-flight command
    logic              prio_q, prio_d;     // requester that wins the next tie
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [1:0]        resp0_q, resp0_d;
    logic [1:0]        resp1_q, resp1_d;
    logic              gnt0, gnt1;
    logic              aw_fin, w_fin;

    // Round-robin grant, only from IDLE and never in a done-pulse cycle.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!ARESET && state_q == StIdle && !done0_q && !done1_q) begin
            if (req0_valid && req1_valid) begin
                gnt0 = ~prio_q;
                gnt1 = prio_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    // Transaction FSM and capture of command/response fields.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        prio_d    = prio_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        resp0_d   = resp0_q;
        resp1_d   = resp1_q;
        aw_fin    = aw_done_q | M_AXI_AWREADY;
        w_fin     = w_done_q | M_AXI_WREADY;
        case (state_q)
            StIdle: begin
                if (gnt0 || gnt1) begin
                    owner_d   = gnt1;
                    prio_d    = gnt0;
                    we_d      = gnt1 ? req1_we : req0_we;
                    addr_d    = gnt1 ? req1_addr : req0_addr;
                    wdata_d   = gnt1 ? req1_wdata : req0_wdata;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = (gnt1 ? req1_we : req0_we) ? StWr : StRdAddr;
                end
            end
            StWr: begin
                // AW and W complete independently; leave once both have.
                aw_done_d = aw_fin;
                w_done_d  = w_fin;
                if (aw_fin && w_fin) begin
                    state_d = StWrResp;
                end
            end
            StWrResp: begin
                if (M_AXI_BVALID) begin
                    if (owner_q) begin
                        resp1_d = M_AXI_BRESP;
                        done1_d = 1'b1;
                    end else begin
                        resp0_d = M_AXI_BRESP;
                        done0_d = 1'b1;
                    end
                    state_d = StIdle;
                end
            end
            StRdAddr: begin
                if (M_AXI_ARREADY) begin
                    state_d = StRdResp;
                end
            end
            StRdResp: begin
                if (M_AXI_RVALID) begin
                    if (owner_q) begin
                        rdata1_d = M_AXI_RDATA;
                        resp1_d  = M_AXI_RRESP;
                        done1_d  = 1'b1;
                    end else begin
                        rdata0_d = M_AXI_RDATA;
                        resp0_d  = M_AXI_RRESP;
                        done0_d  = 1'b1;
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            prio_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            resp0_q   <= '0;
            resp1_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            prio_q    <= prio_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            resp0_q   <= resp0_d;
            resp1_q   <= resp1_d;
        end
    end

`ifdef AXIL_CMD_ARB_STATS_EN
    logic [15:0] wr0_cnt_q, wr0_cnt_d;
    logic [15:0] rd0_cnt_q, rd0_cnt_d;
    logic [15:0] wr1_cnt_q, wr1_cnt_d;
    logic [15:0] rd1_cnt_q, rd1_cnt_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Counters advance together with the done pulse they account for.
    always_comb begin
        wr0_cnt_d = wr0_cnt_q;
        rd0_cnt_d = rd0_cnt_q;
        wr1_cnt_d = wr1_cnt_q;
        rd1_cnt_d = rd1_cnt_q;
        if (done0_d && we_q)  wr0_cnt_d = sat_inc(wr0_cnt_q);
        if (done0_d && !we_q) rd0_cnt_d = sat_inc(rd0_cnt_q);
        if (done1_d && we_q)  wr1_cnt_d = sat_inc(wr1_cnt_q);
        if (done1_d && !we_q) rd1_cnt_d = sat_inc(rd1_cnt_q);
    end

    // Statistics registers.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr0_cnt_q <= '0;
            rd0_cnt_q <= '0;
            wr1_cnt_q <= '0;
            rd1_cnt_q <= '0;
        end else begin
            wr0_cnt_q <= wr0_cnt_d;
            rd0_cnt_q <= rd0_cnt_d;
            wr1_cnt_q <= wr1_cnt_d;
            rd1_cnt_q <= rd1_cnt_d;
        end
    end

    assign req0_wr_cnt = wr0_cnt_q;
    assign req0_rd_cnt = rd0_cnt_q;
    assign req1_wr_cnt = wr1_cnt_q;
    assign req1_rd_cnt = rd1_cnt_q;
`endif

    // Handshake outputs are forced low while reset is held.
    assign M_AXI_AWVALID = !ARESET && state_q == StWr && !aw_done_q;
    assign M_AXI_WVALID  = !ARESET && state_q == StWr && !w_done_q;
    assign M_AXI_BREADY  = !ARESET && state_q == StWrResp;
    assign M_AXI_ARVALID = !ARESET && state_q == StRdAddr;
    assign M_AXI_RREADY  = !ARESET && state_q == StRdResp;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign req0_done  = !ARESET && done0_q;
    assign req1_done  = !ARESET && done1_q;
    assign req0_rdata = rdata0_q;
    assign req1_rdata = rdata1_q;
    assign req0_resp  = resp0_q;
    assign req1_resp  = resp1_q;

endmodule

// File: doc/axil_cmd_arbiter.md
AXIL_CMD_ARBITER -- requirements
Module: axil_cmd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the AXI4-Lite address width.
REQ-002 SHALL have parameter DATA_W, default 32, the data width; only 32 is supported.
REQ-003 SHALL have ports ACLK (in, 1, sole clock) and ARESET (in, 1, synchronous, active-high reset); all logic samples on the rising edge of ACLK.
REQ-004 SHALL have, for each requester n in {0,1}:
- reqn_valid (in, 1, command pending)
- reqn_ready (out, 1, command accepted this cycle)
- reqn_we (in, 1, 1 = write, 0 = read)
- reqn_addr (in, ADDR_W)
- reqn_wdata (in, 32)
- reqn_done (out, 1, one-cycle completion pulse)
- reqn_rdata (out, 32)
- reqn_resp (out, 2, captured BRESP or RRESP)
REQ-005 SHALL have an AXI4-Lite master port M_AXI_*: AWADDR/AWPROT/AWVALID out, AWREADY in; WDATA/WSTRB/WVALID out, WREADY in; BRESP/BVALID in, BREADY out; ARADDR/ARPROT/ARVALID out, ARREADY in; RDATA/RRESP/RVALID in, RREADY out.

Function
REQ-006 SHALL implement the FSM IDLE, WR (AW+W outstanding), WR_RESP, RD_ADDR, RD_RESP.
REQ-007 In IDLE with at least one reqn_valid, the arbiter SHALL grant one requester, pulse its reqn_ready for exactly that cycle, register addr, wdata and we, and enter WR or RD_ADDR on the next cycle.
REQ-008 Arbitration SHALL be round-robin:
- if only one requester is valid, it is granted
- if both are valid, the requester not granted last time wins
- after reset, requester 0 wins the first tie
REQ-009 In WR, AWVALID and WVALID SHALL assert together; each drops independently after its own handshake (VALID and READY both high).
REQ-010 WR SHALL exit to WR_RESP only once both handshakes have completed, in either order or in the same cycle.
REQ-011 In WR_RESP, BREADY SHALL be high. On BVALID, the block SHALL capture BRESP, pulse the granted reqn_done for one cycle and return to IDLE.
REQ-012 In RD_ADDR, ARVALID SHALL be high until ARREADY, then the FSM moves to RD_RESP.
REQ-013 In RD_RESP, RREADY SHALL be high. On RVALID, the block SHALL capture RDATA and RRESP, pulse reqn_done and return to IDLE.
REQ-014 Once asserted, a VALID SHALL NOT deassert and its address/data SHALL NOT change before the matching handshake.
REQ-015 WSTRB SHALL be 4'hF; AWPROT and ARPROT SHALL be 3'b000.
REQ-016 At most one transaction SHALL be outstanding, and no new grant SHALL occur in the cycle a reqn_done pulses.
REQ-017 Minimum latency from grant to done:
- write: 3 cycles, with AWREADY, WREADY and BVALID high immediately
- read: 3 cycles, with ARREADY and RVALID high immediately
REQ-018 reqn_rdata and reqn_resp SHALL hold their last captured values until that requester's next completion.
REQ-019 A requester dropping reqn_valid after grant SHALL NOT affect the in-flight transaction.

Reset
REQ-020 While ARESET is high, the block SHALL:
- enter IDLE
- drive all M_AXI VALID/READY outputs, reqn_ready and reqn_done low
- zero reqn_rdata, reqn_resp and the registered address/data
- reset the round-robin pointer so requester 0 wins the next tie
REQ-021 ARESET asserted mid-transaction SHALL abandon the transaction without a reqn_done pulse; recovery of the slave is the system's responsibility.

Configuration
REQ-022 With AXIL_CMD_ARB_STATS_EN defined, the block SHALL add per-requester outputs reqn_wr_cnt and reqn_rd_cnt (16 bits each).
- each increments on that requester's reqn_done for its transaction type
- each saturates at 16'hFFFF
- each is cleared by ARESET
REQ-023 Without AXIL_CMD_ARB_STATS_EN, those ports and counters SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-024 Req0 writes 0x00000001 to addr 0x0, slave always ready -> AW and W handshake in the same cycle, req0_done 3 cycles after grant, req0_resp=2'b00.
REQ-025 Req0 and req1 both valid continuously after reset, each reading addr 0x4 -> grants alternate 0,1,0,1 and each done carries RDATA=0x00000002.
REQ-026 Write with AWREADY delayed 4 cycles and WREADY immediate -> WVALID drops after 1 cycle, AWVALID holds 4 cycles, and WR_RESP is entered only after AWREADY.
REQ-027 Read returns RRESP=2'b10 -> req1_resp=2'b10, and rdata is updated to the returned value.
REQ-028 ARESET pulsed during WR_RESP -> no req_done pulse, all VALIDs low the next cycle, and the next tie is granted to req0.
REQ-029 With AXIL_CMD_ARB_STATS_EN, four writes then four reads on addresses 0x0-0xC from req0 -> req0_wr_cnt=4, req0_rd_cnt=4, all req1 counts 0, and read data 1,2,3,4.
